// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one APB slave port,
// sequencing SETUP/ACCESS with a saturating timeout and a one-cycle response pulse.
module apb_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_strb,
    input  logic [NUM_REQ*4-1:0]              req_prot,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                resp_valid,
    output logic [DATA_WIDTH-1:0]             resp_rdata,
    output logic                              resp_error,
    output logic [ADDR_WIDTH-1:0]             addr,
    output logic                              write,
    output logic [DATA_WIDTH-1:0]             wdata,
    output logic [DATA_WIDTH/8-1:0]           strb,
    output logic [3:0]                        prot,
    output logic                              sel,
    output logic                              enable,
    input  logic                              ready,
    input  logic [DATA_WIDTH-1:0]             rdata,
    input  logic                              slave_error,
    output logic                              timeout_err,
    output logic [1:0]                        state_dbg
);
    // Handshake: a request transfers in a cycle where req_valid[i] and req_ready[i]
    // are both high; req_ready is raised only in IDLE, only for the round-robin
    // winner, and each accepted request gets exactly one resp_valid[i] pulse later.
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int GW     = $clog2(NUM_REQ);
    localparam int CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]      CNT_MAX   = CW'(TIMEOUT);
    localparam logic [GW-1:0]      LAST_INIT = GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);

    // state_dbg encoding: 0=IDLE 1=SETUP 2=ACCESS 3=RESP
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state, state_nxt;

    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         gnt_id;
    logic [GW-1:0]         winner;
    logic [GW-1:0]         cand;
    logic                  found;
    logic                  accept;
    logic                  timeout_hit;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_write;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [STRB_W-1:0]     win_strb;
    logic [3:0]            win_prot;

    // Search begins one past the last grant so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = last_grant;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_write = 1'b0;
        win_wdata = '0;
        win_strb  = '0;
        win_prot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == GW'(i)) begin
                win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_write = req_write[i];
                win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                win_strb  = req_strb[i*STRB_W +: STRB_W];
                win_prot  = req_prot[i*4 +: 4];
            end
        end
    end

    assign accept      = (state == IDLE) && found;
    assign timeout_hit = (state == ACCESS) && !ready && (cnt == CNT_LAST);
    assign req_ready   = (accept && !rst) ? (ONE << winner) : '0;
    assign resp_valid  = (state == RESP) ? (ONE << gnt_id) : '0;
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sel       = 1'b0;
        enable    = 1'b0;
        case (state)
            IDLE:   if (found) state_nxt = SETUP;
            SETUP: begin
                sel       = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                sel    = 1'b1;
                enable = 1'b1;
                if (ready || timeout_hit) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            write       <= 1'b0;
            wdata       <= '0;
            strb        <= '0;
            prot        <= '0;
            gnt_id      <= '0;
            last_grant  <= LAST_INIT;
            cnt         <= '0;
            resp_rdata  <= '0;
            resp_error  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_hit;
            if (accept) begin
                addr   <= win_addr;
                write  <= win_write;
                wdata  <= win_wdata;
                strb   <= win_strb;
                prot   <= win_prot;
                gnt_id <= winner;
                cnt    <= '0;
            end
            if (state == ACCESS) begin
                if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
                // A ready in the final allowed cycle still wins over the timeout.
                if (ready) begin
                    resp_rdata <= write ? '0 : rdata;
                    resp_error <= slave_error;
                end else if (timeout_hit) begin
                    resp_rdata <= '0;
                    resp_error <= 1'b1;
                end
            end
            if (state == RESP) last_grant <= gnt_id;
        end
    end

endmodule
